// File: rtl/shift_normalizer.sv
// 32-bit normalizer: finds the left shift that puts the word in canonical form
// (MSB set, or bit 30 != bit 31 in signed mode) over three advance-gated stages.
module shift_normalizer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_signed,
    input  logic [31:0] i_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data,
    output logic [4:0]  o_shift_amt,
    output logic        o_zero
);

    // Leading-zero count of a 16-bit half, 0..16.
    function automatic logic [4:0] lz16(input logic [15:0] x);
        logic [4:0] cnt;
        logic       done;
        cnt  = '0;
        done = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!done) begin
                if (x[i]) done = 1'b1;
                else      cnt  = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

    logic        w_adv;
    logic [31:0] w_t;
    logic [4:0]  w_cnt_hi, w_cnt_lo;
    logic [5:0]  w_lz;
    logic        w_zero;
    logic [4:0]  w_amt;

    logic        r1_vld, r1_signed;
    logic [31:0] r1_data;
    logic [4:0]  r1_cnt_hi, r1_cnt_lo;
    logic        r2_vld, r2_signed;
    logic [31:0] r2_data;
    logic [5:0]  r2_lz;

    assign w_adv   = !o_valid || i_ready;
    assign o_ready = w_adv;

    // Negative signed words are inverted so sign-bit counting becomes zero counting.
    assign w_t      = (i_signed && i_data[31]) ? ~i_data : i_data;
    assign w_cnt_hi = lz16(w_t[31:16]);
    assign w_cnt_lo = lz16(w_t[15:0]);

    assign w_lz = (r1_cnt_hi == 5'd16) ? (6'd16 + {1'b0, r1_cnt_lo}) : {1'b0, r1_cnt_hi};

    assign w_zero = (r2_data == 32'd0);

    // Signed lz is always >= 1 (t has bit 31 clear); lz == 32 saturates to 31.
    always_comb begin
        w_amt = '0;
        if (w_zero)         w_amt = '0;
        else if (r2_lz[5])  w_amt = 5'd31;
        else if (r2_signed) w_amt = r2_lz[4:0] - 5'd1;
        else                w_amt = r2_lz[4:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r1_vld      <= 1'b0;
            r1_signed   <= 1'b0;
            r1_data     <= '0;
            r1_cnt_hi   <= '0;
            r1_cnt_lo   <= '0;
            r2_vld      <= 1'b0;
            r2_signed   <= 1'b0;
            r2_data     <= '0;
            r2_lz       <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_shift_amt <= '0;
            o_zero      <= 1'b0;
        end else if (w_adv) begin
            r1_vld      <= i_valid;
            r1_signed   <= i_signed;
            r1_data     <= i_data;
            r1_cnt_hi   <= w_cnt_hi;
            r1_cnt_lo   <= w_cnt_lo;
            r2_vld      <= r1_vld;
            r2_signed   <= r1_signed;
            r2_data     <= r1_data;
            r2_lz       <= w_lz;
            o_valid     <= r2_vld;
            o_data      <= r2_data << w_amt;
            o_shift_amt <= w_amt;
            o_zero      <= w_zero;
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed cases plus random traffic
// against a shift-until-normalized reference model and the inverse property.
module tb_shift_normalizer;

    typedef struct {
        logic [31:0] din;
        logic        sgn;
        logic [31:0] od;
        logic [4:0]  amt;
        logic        z;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_signed = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_data;
    logic [4:0]  o_shift_amt;
    logic        o_zero;

    shift_normalizer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_signed(i_signed), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_shift_amt(o_shift_amt), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    int   nchk = 0, nerr = 0;
    exp_t q[$];
    logic rst_drv = 1'b1;
    logic s_ovld, s_ordy, acc;
    logic held = 1'b0;
    logic [31:0] h_data;
    logic [4:0]  h_amt;
    logic        h_zero;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: shift left one place at a time until the word is normalized.
    function automatic exp_t model(input logic [31:0] d, input logic s);
        exp_t e;
        logic [31:0] x;
        int a;
        x = d;
        a = 0;
        e.din = d; e.sgn = s;
        if (d == 0) begin
            e.od = 0; e.amt = 0; e.z = 1'b1;
            return e;
        end
        if (s) while (a < 31 && x[31] == x[30]) begin x = x << 1; a++; end
        else   while (!x[31]) begin x = x << 1; a++; end
        e.od = x; e.amt = 5'(a); e.z = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic s, input logic [31:0] od,
                                input logic [4:0] amt, input logic z);
        exp_t e;
        e.din = d; e.sgn = s; e.od = od; e.amt = amt; e.z = z;
        return e;
    endfunction

    task automatic step(input logic v, input exp_t e, input logic r);
        exp_t x;
        logic [31:0] inv;
        @(negedge i_clk);
        i_rst = rst_drv; i_valid = v; i_data = e.din; i_signed = e.sgn; i_ready = r;
        #1;
        s_ovld = o_valid;
        s_ordy = o_ready;
        if (held && o_valid) begin
            chk("stall_data", o_data, h_data);
            chk("stall_amt", 32'(o_shift_amt), 32'(h_amt));
            chk("stall_zero", 32'(o_zero), 32'(h_zero));
        end
        held = o_valid && !i_ready && !rst_drv;
        h_data = o_data; h_amt = o_shift_amt; h_zero = o_zero;
        if (o_valid && i_ready) begin
            if (q.size() == 0) chk("spurious_out", 32'(o_valid), 32'd0);
            else begin
                x = q.pop_front();
                chk("data", o_data, x.od);
                chk("amt", 32'(o_shift_amt), 32'(x.amt));
                chk("zero", 32'(o_zero), 32'(x.z));
                if (x.din != 0) begin
                    inv = x.sgn ? 32'($signed(o_data) >>> o_shift_amt) : (o_data >> o_shift_amt);
                    chk("inverse", inv, x.din);
                end
            end
        end
        acc = v && o_ready && !rst_drv;
        if (acc) q.push_back(e);
    endtask

    task automatic idle(input logic r);
        step(1'b0, mk(32'hDEADBEEF, 1'b1, 0, 0, 0), r);
    endtask

    task automatic drain;
        for (int i = 0; i < 60 && q.size() != 0; i++) idle(1'b1);
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        exp_t e;
        // reset state
        idle(1'b1); idle(1'b1);
        rst_drv = 1'b0;
        idle(1'b1);
        chk("rst_valid", 32'(s_ovld), 0);
        chk("rst_data", o_data, 0);
        chk("rst_amt", 32'(o_shift_amt), 0);
        chk("rst_zero", 32'(o_zero), 0);
        chk("rst_ready", 32'(s_ordy), 1);

        // latency
        step(1'b1, mk(32'h00000001, 1'b0, 32'h80000000, 5'd31, 1'b0), 1'b1);
        idle(1'b1); chk("lat_c1", 32'(s_ovld), 0);
        idle(1'b1); chk("lat_c2", 32'(s_ovld), 0);
        idle(1'b1); chk("lat_c3", 32'(s_ovld), 1);

        // directed values
        step(1'b1, mk(32'hFFFF8000, 1'b1, 32'h80000000, 5'd16, 1'b0), 1'b1);
        step(1'b1, mk(32'h00001234, 1'b1, 32'h48D00000, 5'd18, 1'b0), 1'b1);
        step(1'b1, mk(32'hFFFFFFFF, 1'b1, 32'h80000000, 5'd31, 1'b0), 1'b1);
        step(1'b1, mk(32'h00000000, 1'b0, 32'h00000000, 5'd0, 1'b1), 1'b1);
        step(1'b1, mk(32'h00000000, 1'b1, 32'h00000000, 5'd0, 1'b1), 1'b1);
        step(1'b1, mk(32'h80000000, 1'b0, 32'h80000000, 5'd0, 1'b0), 1'b1);
        drain();

        // back-to-back stream with 5-cycle stall
        step(1'b1, mk(32'h00000010, 1'b0, 32'h80000000, 5'd27, 1'b0), 1'b1);
        step(1'b1, mk(32'h00F00000, 1'b0, 32'hF0000000, 5'd8, 1'b0), 1'b1);
        step(1'b1, mk(32'h40000000, 1'b0, 32'h80000000, 5'd1, 1'b0), 1'b1);
        e = mk(32'h00000003, 1'b0, 32'hC0000000, 5'd30, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, e, 1'b0);
            chk("bp_valid", 32'(s_ovld), 1);
            chk("bp_ready", 32'(s_ordy), 0);
        end
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(1'b1, e, 1'b1);
        chk("bp_accept", 32'(acc), 1);
        drain();

        // reset with words in flight
        step(1'b1, mk(32'h00000100, 1'b0, 32'h80000000, 5'd23, 1'b0), 1'b1);
        step(1'b1, mk(32'h00000200, 1'b0, 32'h80000000, 5'd22, 1'b0), 1'b1);
        step(1'b1, mk(32'h00000400, 1'b0, 32'h80000000, 5'd21, 1'b0), 1'b1);
        rst_drv = 1'b1;
        idle(1'b0);
        rst_drv = 1'b0;
        q.delete();
        idle(1'b1);
        chk("mrst_valid", 32'(s_ovld), 0);
        chk("mrst_data", o_data, 0);
        chk("mrst_amt", 32'(o_shift_amt), 0);
        chk("mrst_zero", 32'(o_zero), 0);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            chk("mrst_stale", 32'(s_ovld), 0);
        end

        // random traffic
        for (int n = 0; n < 10000; ) begin
            logic [31:0] d;
            logic s;
            s = 1'($urandom);
            case ($urandom_range(0, 15))
                0:       d = 32'h0;
                1:       d = 32'hFFFFFFFF;
                default: d = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 1) d = ~d;
            step(($urandom_range(0, 3) != 0), model(d, s), ($urandom_range(0, 9) < 7));
            if (acc) n++;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
